// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: byte-stream to GMII transmit framer.
// Emits preamble, SFD, payload, optional zero pad and CRC-32 FCS, then an
// enforced inter-frame gap. A payload underrun aborts the frame with one
// tx_er cycle and discards the rest of the packet.
// Build option: define GMII_TX_FRAMER_PAD_EN to pad short frames to MIN_FRAME.
module gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_err,
  output logic        s_ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  // Frames are only started when the configuration is inside its legal range.
  localparam logic PARAMS_OK = (IFG_BYTES >= 12) && (IFG_BYTES <= 255) &&
                               (MIN_FRAME >= 1) && (MIN_FRAME <= 1500);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
`ifdef GMII_TX_FRAMER_PAD_EN
  localparam logic [10:0] PAD_TARGET = 11'(MIN_FRAME);
`endif

  // The state names what is currently on the GMII outputs; the transition
  // taken in a state decides the byte shown in the following cycle.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
`ifdef GMII_TX_FRAMER_PAD_EN
    ST_PAD  = 3'd4,
`endif
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6,
    ST_DROP = 3'd7
  } state_t;

  state_t      r_state;
  logic [2:0]  r_pre_cnt;      // preamble bytes already shown
  logic [2:0]  r_fcs_idx;      // next FCS byte to show; 4 means all shown
  logic [7:0]  r_ifg_cnt;      // idle cycles already shown
  logic [10:0] r_byte_cnt;     // payload + pad bytes, saturating
  logic [31:0] r_crc;          // running CRC, not yet complemented
  logic        r_frame_err;    // some payload byte carried s_err
  logic        r_last_taken;   // s_last accepted; last payload byte on the wire
  logic        r_ready;
  logic [7:0]  r_txd;
  logic        r_tx_en;
  logic        r_tx_er;
  logic [15:0] r_frame_count;
  logic [7:0]  r_err_count;

  logic [7:0]  w_crc_in;
  logic [31:0] w_crc_next;
  logic [7:0]  w_fcs_byte;
  logic [10:0] w_byte_cnt_inc;
  logic [7:0]  w_err_count_inc;

  // Bit-serial reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Once s_last has been taken the only bytes still fed to the CRC are pad zeros.
  assign w_crc_in        = r_last_taken ? 8'h00 : s_data;
  assign w_crc_next      = crc32_byte(r_crc, w_crc_in);
  assign w_byte_cnt_inc  = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  // Select the complemented CRC byte for FCS positions 1..3 (LSB byte first).
  always_comb begin
    w_fcs_byte = 8'h00;
    case (r_fcs_idx[1:0])
      2'd0:    w_fcs_byte = ~r_crc[7:0];
      2'd1:    w_fcs_byte = ~r_crc[15:8];
      2'd2:    w_fcs_byte = ~r_crc[23:16];
      default: w_fcs_byte = ~r_crc[31:24];
    endcase
  end

  // Framing FSM with registered GMII outputs, handshake and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pre_cnt     <= 3'd0;
      r_fcs_idx     <= 3'd0;
      r_ifg_cnt     <= 8'd0;
      r_byte_cnt    <= 11'd0;
      r_crc         <= CRC_INIT;
      r_frame_err   <= 1'b0;
      r_last_taken  <= 1'b0;
      r_ready       <= 1'b0;
      r_txd         <= 8'h00;
      r_tx_en       <= 1'b0;
      r_tx_er       <= 1'b0;
      r_frame_count <= 16'd0;
      r_err_count   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          r_ready <= 1'b0;
          // The waiting byte is not consumed; it is taken during SFD.
          if (s_valid && PARAMS_OK) begin
            r_state      <= ST_PRE;
            r_txd        <= 8'h55;
            r_tx_en      <= 1'b1;
            r_pre_cnt    <= 3'd1;
            r_crc        <= CRC_INIT;
            r_byte_cnt   <= 11'd0;
            r_frame_err  <= 1'b0;
            r_last_taken <= 1'b0;
          end
        end

        ST_PRE: begin
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b0;
          if (r_pre_cnt == 3'd7) begin
            r_state <= ST_SFD;
            r_txd   <= 8'hD5;
            r_ready <= 1'b1;
          end else begin
            r_txd     <= 8'h55;
            r_pre_cnt <= r_pre_cnt + 3'd1;
          end
        end

        ST_SFD, ST_DATA: begin
          r_tx_en <= 1'b1;
          if (r_last_taken) begin
            // Last payload byte is on the wire; choose pad or FCS next.
            r_tx_er <= 1'b0;
`ifdef GMII_TX_FRAMER_PAD_EN
            if (r_byte_cnt < PAD_TARGET) begin
              r_state    <= ST_PAD;
              r_txd      <= 8'h00;
              r_crc      <= w_crc_next;
              r_byte_cnt <= w_byte_cnt_inc;
            end else
`endif
            begin
              r_state   <= ST_FCS;
              r_txd     <= ~r_crc[7:0];
              r_fcs_idx <= 3'd1;
            end
          end else if (s_valid) begin
            r_state     <= ST_DATA;
            r_txd       <= s_data;
            r_tx_er     <= s_err;
            r_crc       <= w_crc_next;
            r_byte_cnt  <= w_byte_cnt_inc;
            r_frame_err <= r_frame_err | s_err;
            if (s_last) begin
              r_ready      <= 1'b0;
              r_last_taken <= 1'b1;
            end
          end else begin
            // Underrun: one poisoned cycle, then discard to end of packet.
            r_state     <= ST_DROP;
            r_txd       <= 8'h00;
            r_tx_er     <= 1'b1;
            r_err_count <= w_err_count_inc;
          end
        end

`ifdef GMII_TX_FRAMER_PAD_EN
        ST_PAD: begin
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b0;
          if (r_byte_cnt < PAD_TARGET) begin
            r_txd      <= 8'h00;
            r_crc      <= w_crc_next;
            r_byte_cnt <= w_byte_cnt_inc;
          end else begin
            r_state   <= ST_FCS;
            r_txd     <= ~r_crc[7:0];
            r_fcs_idx <= 3'd1;
          end
        end
`endif

        ST_FCS: begin
          r_tx_er <= 1'b0;
          if (r_fcs_idx[2]) begin
            r_state   <= ST_IFG;
            r_txd     <= 8'h00;
            r_tx_en   <= 1'b0;
            r_ifg_cnt <= 8'd1;
            if (r_frame_err) begin
              r_err_count <= w_err_count_inc;
            end else begin
              r_frame_count <= r_frame_count + 16'd1;
            end
          end else begin
            r_txd     <= w_fcs_byte;
            r_tx_en   <= 1'b1;
            r_fcs_idx <= r_fcs_idx + 3'd1;
          end
        end

        ST_IFG: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          if (r_ifg_cnt == IFG_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 8'd1;
          end
        end

        ST_DROP: begin
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          if (s_valid && s_last) begin
            r_ready   <= 1'b0;
            r_state   <= ST_IFG;
            r_ifg_cnt <= 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_txd   <= 8'h00;
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = r_ready;
  assign gmii_txd    = r_txd;
  assign gmii_tx_en  = r_tx_en;
  assign gmii_tx_er  = r_tx_er;
  assign busy        = (r_state != ST_IDLE);
  assign frame_count = r_frame_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: captures every GMII cycle and checks
// framing, FCS, underrun, s_err, back-to-back gap and mid-frame reset.
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_err;
  logic        s_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  always #4 clk = ~clk;

  gmii_tx_framer dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_err      (s_err),
    .s_ready    (s_ready),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .busy       (busy),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_txd  [0:4095];
  logic       cap_en   [0:4095];
  logic       cap_er   [0:4095];
  logic       cap_rdy  [0:4095];
  logic       cap_busy [0:4095];
  int         cap_n;

  logic [7:0] tx_buf  [0:255];
  logic       tx_last [0:255];
  logic       tx_err  [0:255];
  logic [7:0] mdl_buf [0:255];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample all outputs 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cap_n < 4096) begin
      cap_txd[cap_n]  = gmii_txd;
      cap_en[cap_n]   = gmii_tx_en;
      cap_er[cap_n]   = gmii_tx_er;
      cap_rdy[cap_n]  = s_ready;
      cap_busy[cap_n] = busy;
      cap_n++;
    end
  endtask

  // Push n bytes of tx_buf; optionally withhold s_valid for one cycle once
  // gap_at bytes have been accepted.
  task automatic send(input int n, input int gap_at);
    int  i;
    int  guard;
    bit  gapped;
    bit  acc;
    i = 0; guard = 0; gapped = 0;
    s_valid = 1'b1; s_data = tx_buf[0]; s_last = tx_last[0]; s_err = tx_err[0];
    while (i < n && guard < 3000) begin
      if (i == gap_at && !gapped) begin
        gapped = 1;
        s_valid = 1'b0;
        tick(); guard++;
        s_valid = 1'b1;
      end else begin
        acc = s_ready && s_valid;
        tick(); guard++;
        if (acc) begin
          i++;
          if (i < n) begin
            s_data = tx_buf[i]; s_last = tx_last[i]; s_err = tx_err[i];
          end else begin
            s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = 8'h00;
          end
        end
      end
    end
    chk("send_all_accepted", i, n);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 500) begin
      tick(); g++;
    end
    chk("return_to_idle", busy, 1'b0);
  endtask

  function automatic logic [31:0] crc_model(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {24'h0, mdl_buf[k]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic int find_en(input int from);
    for (int k = from; k < cap_n; k++) begin
      if (cap_en[k]) return k;
    end
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int k;
    k = from;
    while (k >= 0 && k < cap_n && cap_en[k]) k++;
    return k - from;
  endfunction

  // Check one complete frame starting at capture index s with n bytes before FCS.
  task automatic check_good_frame(input string tag, input int s, input int n);
    int pre;
    int mism;
    logic [31:0] fcs;
    pre = 0; mism = 0;
    for (int k = 0; k < 7; k++) if (cap_txd[s+k] == 8'h55) pre++;
    chk({tag, "_preamble"}, pre, 7);
    chk({tag, "_sfd"}, cap_txd[s+7], 8'hD5);
    for (int k = 0; k < n; k++) if (cap_txd[s+8+k] !== mdl_buf[k]) mism++;
    chk({tag, "_payload_mismatches"}, mism, 0);
    fcs = {cap_txd[s+8+n+3], cap_txd[s+8+n+2], cap_txd[s+8+n+1], cap_txd[s+8+n]};
    chk({tag, "_fcs"}, fcs, crc_model(n));
    chk({tag, "_tx_en_length"}, run_len(s), 8 + n + 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int s2;
    int cnt;
    int last;
    logic [7:0] ascii [0:8];

    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = 8'h00;
    cap_n = 0;
    tick(); tick();
    // Reset values
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_tx_er", gmii_tx_er, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_err_count", err_count, 8'd0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_tx_en", gmii_tx_en, 1'b0);

    // T1: "123456789", known FCS 26 39 F4 CB
    for (int k = 0; k < 9; k++) begin
      tx_buf[k] = 8'h31 + 8'(k); tx_last[k] = (k == 8); tx_err[k] = 1'b0;
      mdl_buf[k] = tx_buf[k];
    end
    cap_n = 0;
    send(9, -1);
    wait_idle();
    s = find_en(0);
    chk("t1_first_preamble_cycle", s, 0);
    chk("t1_ready_low_in_pre", cap_rdy[6], 1'b0);
    chk("t1_ready_in_sfd", cap_rdy[7], 1'b1);
    chk("t1_first_payload", cap_txd[8], 8'h31);
    chk("t1_last_payload", cap_txd[16], 8'h39);
    chk("t1_fcs0", cap_txd[17], 8'h26);
    chk("t1_fcs1", cap_txd[18], 8'h39);
    chk("t1_fcs2", cap_txd[19], 8'hF4);
    chk("t1_fcs3", cap_txd[20], 8'hCB);
    chk("t1_tx_en_length", run_len(0), 21);
    cnt = 0;
    for (int k = 0; k < cap_n; k++) if (cap_er[k]) cnt++;
    chk("t1_tx_er_cycles", cnt, 0);
    cnt = 0;
    for (int k = 21; k < cap_n; k++) if (cap_busy[k] && !cap_en[k]) cnt++;
    chk("t1_ifg_cycles", cnt, 12);
    chk("t1_frame_count", frame_count, 16'd1);
    chk("t1_err_count", err_count, 8'd0);

    // T2: 14-byte payload; padded to 60 only when padding is compiled in
    for (int k = 0; k < 14; k++) begin
      tx_buf[k] = 8'hC0 ^ 8'(k * 7); tx_last[k] = (k == 13); tx_err[k] = 1'b0;
    end
    for (int k = 0; k < 60; k++) mdl_buf[k] = (k < 14) ? tx_buf[k] : 8'h00;
    cap_n = 0;
    send(14, -1);
    wait_idle();
    s = find_en(0);
`ifdef GMII_TX_FRAMER_PAD_EN
    check_good_frame("t2_padded", s, 60);
`else
    check_good_frame("t2_unpadded", s, 14);
`endif
    chk("t2_frame_count", frame_count, 16'd2);

    // T3: underrun after 6 accepted bytes of a 20-byte packet
    for (int k = 0; k < 20; k++) begin
      tx_buf[k] = 8'hA0 + 8'(k); tx_last[k] = (k == 19); tx_err[k] = 1'b0;
      mdl_buf[k] = tx_buf[k];
    end
    cap_n = 0;
    send(20, 6);
    wait_idle();
    s = find_en(0);
    chk("t3_tx_en_length", run_len(s), 15);
    chk("t3_abort_tx_er", cap_er[s+14], 1'b1);
    chk("t3_abort_txd", cap_txd[s+14], 8'h00);
    chk("t3_sixth_byte", cap_txd[s+13], 8'hA5);
    cnt = 0;
    for (int k = 0; k < cap_n; k++) if (cap_er[k]) cnt++;
    chk("t3_tx_er_cycles", cnt, 1);
    chk("t3_no_later_tx_en", find_en(s + 15), -1);
    chk("t3_err_count", err_count, 8'd1);
    chk("t3_frame_count", frame_count, 16'd2);

    // T4: s_err on byte 5 of a 64-byte frame
    for (int k = 0; k < 64; k++) begin
      tx_buf[k] = 8'(k * 3 + 1); tx_last[k] = (k == 63); tx_err[k] = (k == 4);
      mdl_buf[k] = tx_buf[k];
    end
    cap_n = 0;
    send(64, -1);
    wait_idle();
    s = find_en(0);
    check_good_frame("t4", s, 64);
    chk("t4_tx_er_on_byte5", cap_er[s+12], 1'b1);
    cnt = 0;
    for (int k = 0; k < cap_n; k++) if (cap_er[k]) cnt++;
    chk("t4_tx_er_cycles", cnt, 1);
    chk("t4_err_count", err_count, 8'd2);
    chk("t4_frame_count", frame_count, 16'd2);

    // T5: two 64-byte frames back-to-back with s_valid held high
    for (int k = 0; k < 128; k++) begin
      tx_buf[k]  = (k < 64) ? 8'(k) : 8'hFF - 8'(k);
      tx_last[k] = (k == 63) || (k == 127);
      tx_err[k]  = 1'b0;
    end
    cap_n = 0;
    send(128, -1);
    wait_idle();
    s = find_en(0);
    for (int k = 0; k < 64; k++) mdl_buf[k] = tx_buf[k];
    check_good_frame("t5_frame_a", s, 64);
    s2 = find_en(s + 76);
    chk("t5_gap_cycles", s2 - (s + 76), 13);
    for (int k = 0; k < 64; k++) mdl_buf[k] = tx_buf[64+k];
    check_good_frame("t5_frame_b", s2, 64);
    chk("t5_frame_count", frame_count, 16'd4);

    // T6: reset while the second FCS byte is on the wire
    for (int k = 0; k < 9; k++) ascii[k] = 8'h31 + 8'(k);
    for (int k = 0; k < 9; k++) begin
      tx_buf[k] = ascii[k]; tx_last[k] = (k == 8); tx_err[k] = 1'b0; mdl_buf[k] = ascii[k];
    end
    cap_n = 0;
    send(9, -1);
    tick(); tick();
    last = cap_n - 1;
    chk("t6_fcs_byte2_on_wire", cap_txd[last], 8'h39);
    reset = 1'b1;
    tick();
    chk("t6_rst_tx_en", gmii_tx_en, 1'b0);
    chk("t6_rst_tx_er", gmii_tx_er, 1'b0);
    chk("t6_rst_txd", gmii_txd, 8'h00);
    chk("t6_rst_s_ready", s_ready, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_frame_count", frame_count, 16'd0);
    chk("t6_rst_err_count", err_count, 8'd0);
    reset = 1'b0;
    tick();
    cap_n = 0;
    send(9, -1);
    wait_idle();
    s = find_en(0);
    check_good_frame("t6_after_reset", s, 9);
    chk("t6_frame_count", frame_count, 16'd1);
    chk("t6_err_count", err_count, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit framing stage that feeds the GMII transmit inputs of the 1000BASE-X/SGMII PCS/PMA core. It accepts a byte-wide packet stream with a valid/ready/last handshake and emits a complete 802.3 frame on GMII: preamble, SFD, payload, optional zero padding and FCS, then an enforced inter-frame gap. It runs on the MAC-side GMII clock. Payload underrun aborts the frame cleanly.

## Interface
- IFG_BYTES, 12: minimum idle cycles (gmii_tx_en low) between frames; legal 12..255.
- MIN_FRAME, 60: minimum bytes before FCS when padding is compiled in; legal 1..1500.
- clk  in  1  GMII transmit clock, 125 MHz.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- s_data  in  8  payload byte (DA first, no preamble, no FCS).
- s_valid  in  1  s_data/s_last/s_err valid.
- s_last  in  1  final payload byte of frame.
- s_err  in  1  mark this byte corrupt (forwarded as gmii_tx_er).
- s_ready  out  1  block accepts a byte this cycle.
- gmii_txd  out  8  to PCS gmii_txd.
- gmii_tx_en  out  1  to PCS gmii_tx_en.
- gmii_tx_er  out  1  to PCS gmii_tx_er.
- busy  out  1  state != IDLE.
- frame_count  out  16  good frames sent, wraps at 0xFFFF.
- err_count  out  8  aborted or errored frames, saturates at 0xFF.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP.
- IDLE: s_ready=0. s_valid=1 -> PRE (byte not consumed).
- PRE: 7 cycles gmii_txd=0x55, tx_en=1 -> SFD.
- SFD: gmii_txd=0xD5; s_ready=1 in this cycle -> DATA.
- DATA: s_ready=1. Each accepted byte appears on gmii_txd next cycle with tx_en=1, tx_er=s_err. Byte counter (11 bit, saturating) increments. Accepted s_last -> PAD if counter<MIN_FRAME and padding compiled in, else FCS.
- Underrun (s_valid=0 in DATA): emit one cycle tx_en=1, tx_er=1, txd=0x00; err_count++; -> DROP.
- DROP: s_ready=1, tx_en=0; discard until accepted s_last -> IFG. If s_last coincides with the underrun cycle's next byte, DROP lasts one cycle.
- PAD: emit 0x00 until byte counter==MIN_FRAME -> FCS. s_ready=0.
- FCS: 4 bytes, CRC-32 IEEE (reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement) over payload+pad, LSB byte first. -> IFG.
- IFG: tx_en=0, txd=0x00 for IFG_BYTES cycles -> IDLE. frame_count++ on FCS exit if no byte carried s_err; else err_count++.
- s_ready is 0 in IDLE, PRE, PAD, FCS, IFG.

## Timing
- All GMII outputs registered; reset values: gmii_txd=0x00, tx_en=0, tx_er=0, s_ready=0, busy=0, frame_count=0, err_count=0, state IDLE, CRC=0xFFFFFFFF.
- s_valid rises in IDLE at cycle 0 -> first 0x55 at cycle 1, SFD at cycle 8, first payload byte at cycle 9.
- Payload byte accepted at cycle n appears on GMII at cycle n+1; tx_en contiguous from first preamble byte to last FCS byte.
- Back-to-back: s_valid held high in last IFG cycle -> IDLE one cycle, preamble next; frame-to-frame gap = IFG_BYTES+1 cycles.
- reset mid-frame: next edge forces IDLE, tx_en=0, no tx_er, no FCS; counters cleared.
- Byte counter saturates at 2047; no length limit enforced.

## Configuration
- GMII_TX_FRAMER_PAD_EN defined: frames shorter than MIN_FRAME payload bytes zero-padded to MIN_FRAME; FCS covers pad.
- Undefined: PAD state removed; s_last goes straight to FCS regardless of length; MIN_FRAME unused.

## Test plan
- Pad off, payload ASCII "123456789" -> GMII: 7x0x55, 0xD5, 0x31..0x39, 0x26 0x39 0xF4 0xCB, tx_en low 12 cycles; frame_count=1.
- Pad on, 14-byte payload -> 46 bytes 0x00 after payload, 60 bytes before FCS, FCS matches software CRC model; total tx_en 72 cycles.
- s_valid dropped for one cycle mid-payload -> one cycle tx_en=1 tx_er=1, tx_en low, rest discarded to s_last; err_count=1, frame_count unchanged.
- s_err=1 on byte 5 of 64-byte frame -> tx_er=1 only on that GMII byte, FCS sent, err_count=1.
- Two 64-byte frames back-to-back, s_valid always high -> exactly 13 idle cycles between frames, frame_count=2.
- reset asserted during FCS byte 2 -> next cycle tx_en=0, all outputs and counters at reset values, next frame starts cleanly.
